// File: rtl/bcd_score_counter.sv
// N-digit BCD counter with add/subtract of a BCD operand, parallel load,
// synchronous clear, wrap or saturate on overflow, and registered flags/pulses.
module bcd_score_counter #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  op_valid,
  input  logic                  op_sub,
  input  logic [4*DIGITS-1:0]   op_value,
  input  logic                  enable,
  input  logic                  down,
  output logic [4*DIGITS-1:0]   value,
  output logic                  carry_out,
  output logic                  borrow_out,
  output logic                  overflow,
  output logic                  bad_bcd,
  output logic                  is_zero
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0] value_q, value_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic         ovf_q, ovf_d;
  logic         bad_q, bad_d;
  logic         zero_q, zero_d;

  logic [W-1:0] operand;
  logic         do_sub;
  logic [W-1:0] sum_v, diff_v;
  logic         sum_c, diff_b;
  logic [4:0]   dsum, dsub;
  logic         rc, rb;

  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // A single-step enable is just an op with operand 1 and direction from down.
  always_comb begin
    operand = op_valid ? op_value : W'(1);
    do_sub  = op_valid ? op_sub : down;
  end

  always_comb begin
    sum_v  = '0;
    diff_v = '0;
    dsum   = '0;
    dsub   = '0;
    rc     = 1'b0;
    rb     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, value_q[4*i +: 4]} + {1'b0, operand[4*i +: 4]} + {4'b0, rc};
      if (dsum > 5'd9) begin
        sum_v[4*i +: 4] = 4'(dsum - 5'd10);
        rc = 1'b1;
      end else begin
        sum_v[4*i +: 4] = dsum[3:0];
        rc = 1'b0;
      end
      dsub = {1'b0, operand[4*i +: 4]} + {4'b0, rb};
      if ({1'b0, value_q[4*i +: 4]} < dsub) begin
        diff_v[4*i +: 4] = 4'({1'b0, value_q[4*i +: 4]} + 5'd10 - dsub);
        rb = 1'b1;
      end else begin
        diff_v[4*i +: 4] = 4'({1'b0, value_q[4*i +: 4]} - dsub);
        rb = 1'b0;
      end
    end
    sum_c  = rc;
    diff_b = rb;
  end

  always_comb begin
    value_d  = value_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    ovf_d    = ovf_q;
    bad_d    = bad_q;
    if (clear) begin
      value_d = '0;
      ovf_d   = 1'b0;
      bad_d   = 1'b0;
    end else if (load) begin
      if (is_bcd(load_value)) value_d = load_value;
      else                    bad_d   = 1'b1;
    end else if (op_valid || enable) begin
      if (!is_bcd(operand)) begin
        bad_d = 1'b1;
      end else if (do_sub) begin
        value_d = diff_v;
        if (diff_b) begin
          borrow_d = 1'b1;
          ovf_d    = 1'b1;
          if (SATURATE) value_d = '0;
        end
      end else begin
        value_d = sum_v;
        if (sum_c) begin
          carry_d = 1'b1;
          ovf_d   = 1'b1;
          if (SATURATE) value_d = ALL_NINES;
        end
      end
    end
    zero_d = (value_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      value_q  <= value_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
      zero_q   <= zero_d;
    end
  end

  assign value      = value_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;
  assign bad_bcd    = bad_q;
  assign is_zero    = zero_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench for bcd_score_counter: four instances (4-digit wrap, 4-digit saturate,
// 1-digit wrap, 8-digit wrap) share controls and are checked against a decimal model.
module tb_bcd_score_counter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0, load = 1'b0, op_valid = 1'b0, op_sub = 1'b0;
  logic        enable = 1'b0, down = 1'b0;
  logic [31:0] lv_bus = '0, op_bus = '0;

  logic [15:0] v4w, v4s;
  logic [3:0]  v1w;
  logic [31:0] v8w;
  logic c4w, b4w, o4w, x4w, z4w;
  logic c4s, b4s, o4s, x4s, z4s;
  logic c1w, b1w, o1w, x1w, z1w;
  logic c8w, b8w, o8w, x8w, z8w;

  int n_checks = 0;
  int n_errors = 0;

  longint m_val[4];
  bit     m_c[4], m_b[4], m_o[4], m_x[4];

  always #5 clock = ~clock;

  bcd_score_counter #(.DIGITS(4), .SATURATE(1'b0)) u4w (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(lv_bus[15:0]),
    .op_valid(op_valid), .op_sub(op_sub), .op_value(op_bus[15:0]), .enable(enable), .down(down),
    .value(v4w), .carry_out(c4w), .borrow_out(b4w), .overflow(o4w), .bad_bcd(x4w), .is_zero(z4w));
  bcd_score_counter #(.DIGITS(4), .SATURATE(1'b1)) u4s (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(lv_bus[15:0]),
    .op_valid(op_valid), .op_sub(op_sub), .op_value(op_bus[15:0]), .enable(enable), .down(down),
    .value(v4s), .carry_out(c4s), .borrow_out(b4s), .overflow(o4s), .bad_bcd(x4s), .is_zero(z4s));
  bcd_score_counter #(.DIGITS(1), .SATURATE(1'b0)) u1w (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(lv_bus[3:0]),
    .op_valid(op_valid), .op_sub(op_sub), .op_value(op_bus[3:0]), .enable(enable), .down(down),
    .value(v1w), .carry_out(c1w), .borrow_out(b1w), .overflow(o1w), .bad_bcd(x1w), .is_zero(z1w));
  bcd_score_counter #(.DIGITS(8), .SATURATE(1'b0)) u8w (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .load_value(lv_bus),
    .op_valid(op_valid), .op_sub(op_sub), .op_value(op_bus), .enable(enable), .down(down),
    .value(v8w), .carry_out(c8w), .borrow_out(b8w), .overflow(o8w), .bad_bcd(x8w), .is_zero(z8w));

  function automatic int dig(input int k);
    case (k)
      0, 1:    return 4;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic bit sat(input int k);
    return (k == 1);
  endfunction

  function automatic longint pow10(input int d);
    longint r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic bit nib_ok(input logic [31:0] v, input int d);
    for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint to_int(input logic [31:0] v, input int d);
    longint r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input longint x, input int d);
    logic [31:0] r = '0;
    longint t = x;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: apply the highest-priority request with plain integer arithmetic.
  task automatic model_step(input int k);
    int d = dig(k);
    longint md = pow10(d);
    longint n, r;
    logic [31:0] opv;
    bit sub;
    m_c[k] = 1'b0;
    m_b[k] = 1'b0;
    if (clear) begin
      m_val[k] = 0; m_o[k] = 1'b0; m_x[k] = 1'b0;
    end else if (load) begin
      if (nib_ok(lv_bus, d)) m_val[k] = to_int(lv_bus, d);
      else                   m_x[k] = 1'b1;
    end else if (op_valid || enable) begin
      opv = op_valid ? op_bus : 32'd1;
      sub = op_valid ? op_sub : down;
      if (!nib_ok(opv, d)) begin
        m_x[k] = 1'b1;
      end else begin
        n = to_int(opv, d);
        if (sub) begin
          r = m_val[k] - n;
          if (r < 0) begin
            m_b[k] = 1'b1; m_o[k] = 1'b1;
            m_val[k] = sat(k) ? 0 : r + md;
          end else m_val[k] = r;
        end else begin
          r = m_val[k] + n;
          if (r >= md) begin
            m_c[k] = 1'b1; m_o[k] = 1'b1;
            m_val[k] = sat(k) ? md - 1 : r - md;
          end else m_val[k] = r;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_val[k] = 0; m_c[k] = 0; m_b[k] = 0; m_o[k] = 0; m_x[k] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic [31:0] v, input logic c, input logic b,
                            input logic o, input logic x, input logic z);
    chk($sformatf("u%0d value", k), v, to_bcd(m_val[k], dig(k)));
    chk($sformatf("u%0d carry_out", k), {31'b0, c}, {31'b0, m_c[k]});
    chk($sformatf("u%0d borrow_out", k), {31'b0, b}, {31'b0, m_b[k]});
    chk($sformatf("u%0d overflow", k), {31'b0, o}, {31'b0, m_o[k]});
    chk($sformatf("u%0d bad_bcd", k), {31'b0, x}, {31'b0, m_x[k]});
    chk($sformatf("u%0d is_zero", k), {31'b0, z}, {31'b0, (m_val[k] == 0)});
  endtask

  task automatic check_all();
    check_inst(0, {16'b0, v4w}, c4w, b4w, o4w, x4w, z4w);
    check_inst(1, {16'b0, v4s}, c4s, b4s, o4s, x4s, z4s);
    check_inst(2, {28'b0, v1w}, c1w, b1w, o1w, x1w, z1w);
    check_inst(3, v8w, c8w, b8w, o8w, x8w, z8w);
  endtask

  // Inputs are already stable here; model then DUT advance on the same edge.
  task automatic tick();
    for (int k = 0; k < 4; k++) model_step(k);
    @(posedge clock);
    #1;
    check_all();
    clear = 1'b0; load = 1'b0; op_valid = 1'b0; enable = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] v);
    lv_bus = v; load = 1'b1; tick();
  endtask

  task automatic do_op(input logic s, input logic [31:0] v);
    op_bus = v; op_sub = s; op_valid = 1'b1; tick();
  endtask

  task automatic do_en(input logic dn);
    down = dn; enable = 1'b1; tick();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 39) == 0)     r[4*i +: 4] = 4'($urandom_range(10, 15));
      else if ($urandom_range(0, 2) == 0) r[4*i +: 4] = 4'd9;
      else                                r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Upward wrap: 4-digit 9998 -> 9999, 0000, 0001; 1-digit 8 -> 9, 0, 1; 8-digit likewise.
    do_load(32'h9999_9998);
    do_en(1'b0);
    do_en(1'b0);
    do_en(1'b0);

    // Downward underflow, then saturated instance pulses again on a further decrement.
    do_load(32'h0000_0003);
    do_op(1'b1, 32'h0000_0005);
    do_en(1'b1);

    // Decimal carry chain 0195 + 0905 = 1100.
    do_load(32'h0000_0195);
    do_op(1'b0, 32'h0000_0905);

    // 0 - 1 from cleared state.
    clear = 1'b1; tick();
    do_op(1'b1, 32'h0000_0001);

    // Priority: clear beats load and enable in the same cycle.
    lv_bus = 32'h0000_1234; load = 1'b1; enable = 1'b1; clear = 1'b1; tick();
    do_load(32'h0000_12A4);
    do_load(32'h0000_0010);
    op_bus = 32'h0000_0022; op_sub = 1'b0; op_valid = 1'b1; down = 1'b0; enable = 1'b1; tick();
    do_op(1'b0, 32'h0000_00B0);

    // Zero operands at both boundaries are no-ops.
    do_load(32'h9999_9999);
    do_op(1'b0, 32'h0);
    do_en(1'b0);
    do_op(1'b1, 32'h0);
    clear = 1'b1; tick();
    do_op(1'b1, 32'h0);

    // Mid-count asynchronous reset.
    do_load(32'h0000_0042);
    do_en(1'b0);
    do_en(1'b1);
    async_reset();

    for (int i = 0; i < 400; i++) begin
      clear    = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 7) == 0);
      op_valid = ($urandom_range(0, 2) == 0);
      op_sub   = 1'($urandom_range(0, 1));
      enable   = 1'($urandom_range(0, 1));
      down     = 1'($urandom_range(0, 1));
      lv_bus   = rand_bcd();
      op_bus   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : rand_bcd();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
